// File: rtl/drop_display_seq.sv
// drop_display_seq: registered baggage-drop sequencer with a hysteresis
// temperature compare, a timed drop pulse, four 7-segment digit registers
// and a time-multiplexed digit bus.
// Optional drop counter: define DROP_DISPLAY_SEQ_DROP_COUNT_EN.
module drop_display_seq #(
  parameter int unsigned T_WIDTH     = 16,
  parameter int unsigned HYST        = 0,
  parameter int unsigned DROP_CYCLES = 8,
  parameter int unsigned SCAN_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [T_WIDTH-1:0] t_act,
  input  logic [T_WIDTH-1:0] t_lim,
  input  logic               drop_en,
  output logic               drop_activated,
  output logic [6:0]         seven_seg1,
  output logic [6:0]         seven_seg2,
  output logic [6:0]         seven_seg3,
  output logic [6:0]         seven_seg4,
  output logic [6:0]         seg_mux,
  output logic [3:0]         an,
  output logic [1:0]         state_o
`ifdef DROP_DISPLAY_SEQ_DROP_COUNT_EN
  ,
  output logic [CNT_W-1:0]   drop_count
`endif
);

  if (DROP_CYCLES < 1 || SCAN_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("drop_display_seq: DROP_CYCLES, SCAN_CYCLES and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    COLD = 2'd0,
    DROP = 2'd1,
    HOT  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_O = 7'b1011100;
  localparam logic [6:0] SEG_L = 7'b0111000;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_R = 7'b1010000;
  localparam logic [6:0] SEG_P = 7'b1110011;
  localparam logic [6:0] SEG_H = 7'b1110110;
  localparam logic [6:0] SEG_T = 7'b1111000;
  localparam logic [6:0] SEG_N = 7'b1010100;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_B = 7'b0000000;

  localparam int unsigned DW = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
  localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DROP_LOAD = DW'(DROP_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [T_WIDTH:0] HYST_W = (T_WIDTH + 1)'(HYST);

  state_t        state, state_nx;
  logic [DW-1:0] cnt, cnt_nx;
  logic          sync1, en_s;
  logic          cold, hot;
  logic [27:0]   seg_nx;
  logic [SW-1:0] scan_cnt, scan_cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic [6:0]    seg_mux_nx;

  // Four digits of a state's display, leftmost digit in the top bits.
  function automatic logic [27:0] disp(input state_t s);
    case (s)
      COLD:    disp = {SEG_C, SEG_O, SEG_L, SEG_D};
      DROP:    disp = {SEG_D, SEG_R, SEG_O, SEG_P};
      HOT:     disp = {SEG_B, SEG_H, SEG_O, SEG_T};
      DONE:    disp = {SEG_D, SEG_O, SEG_N, SEG_E};
      default: disp = {SEG_C, SEG_O, SEG_L, SEG_D};
    endcase
  endfunction

  // One extra bit keeps t_act + HYST from wrapping.
  assign cold = ({1'b0, t_act} + HYST_W) < {1'b0, t_lim};
  assign hot  = t_act > t_lim;

  // Two-flop synchroniser for the asynchronous drop request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      en_s  <= 1'b0;
    end else begin
      sync1 <= drop_en;
      en_s  <= sync1;
    end
  end

  // Next-state decode and drop-pulse countdown.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      COLD: begin
        if (en_s && cold) begin
          state_nx = DROP;
          cnt_nx   = DROP_LOAD;
        end else if (en_s && hot) begin
          state_nx = HOT;
        end
      end
      DROP: begin
        if (hot)            state_nx = HOT;
        else if (cnt == '0) state_nx = DONE;
        else                cnt_nx   = cnt - 1'b1;
      end
      HOT:     if (!en_s) state_nx = COLD;
      DONE:    if (!en_s) state_nx = COLD;
      default: state_nx = COLD;
    endcase
  end

  // Scan index advance and multiplexed digit pick; uses the next-cycle digit
  // values so seg_mux always matches the digit register it selects.
  always_comb begin
    seg_nx      = disp(state_nx);
    scan_cnt_nx = scan_cnt + 1'b1;
    idx_nx      = idx;
    if (scan_cnt == SCAN_LAST) begin
      scan_cnt_nx = '0;
      idx_nx      = idx + 2'd1;
    end
    case (idx_nx)
      2'd0:    seg_mux_nx = seg_nx[27:21];
      2'd1:    seg_mux_nx = seg_nx[20:14];
      2'd2:    seg_mux_nx = seg_nx[13:7];
      default: seg_mux_nx = seg_nx[6:0];
    endcase
  end

  // State, pulse and display registers, all loaded from next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= COLD;
      cnt            <= '0;
      drop_activated <= 1'b0;
      seven_seg1     <= SEG_C;
      seven_seg2     <= SEG_O;
      seven_seg3     <= SEG_L;
      seven_seg4     <= SEG_D;
      scan_cnt       <= '0;
      idx            <= 2'd0;
      an             <= 4'b0001;
      seg_mux        <= SEG_C;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      drop_activated <= (state_nx == DROP);
      seven_seg1     <= seg_nx[27:21];
      seven_seg2     <= seg_nx[20:14];
      seven_seg3     <= seg_nx[13:7];
      seven_seg4     <= seg_nx[6:0];
      scan_cnt       <= scan_cnt_nx;
      idx            <= idx_nx;
      an             <= 4'b0001 << idx_nx;
      seg_mux        <= seg_mux_nx;
    end
  end

  assign state_o = state;

`ifdef DROP_DISPLAY_SEQ_DROP_COUNT_EN
  logic drop_done;
  assign drop_done = (state == DROP) && !hot && (cnt == '0);

  // Saturating count of completed (non-aborted) drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       drop_count <= '0;
    else if (drop_done && drop_count != '1) drop_count <= drop_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_drop_display_seq.sv
// Directed, table-driven bench for drop_display_seq (HYST=5, CNT_W=2).
module tb_drop_display_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] t_act, t_lim;
  logic        drop_en;
  logic        drop_activated;
  logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4, seg_mux;
  logic [3:0]  an;
  logic [1:0]  state_o;
`ifdef DROP_DISPLAY_SEQ_DROP_COUNT_EN
  logic [1:0]  drop_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  drop_display_seq #(
    .T_WIDTH(16), .HYST(5), .DROP_CYCLES(8), .SCAN_CYCLES(4), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en),
    .drop_activated(drop_activated),
    .seven_seg1(seven_seg1), .seven_seg2(seven_seg2),
    .seven_seg3(seven_seg3), .seven_seg4(seven_seg4),
    .seg_mux(seg_mux), .an(an), .state_o(state_o)
`ifdef DROP_DISPLAY_SEQ_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  typedef struct {
    logic [15:0] ta;
    logic [15:0] tl;
    logic        en;
    int          cyc;
    logic [1:0]  st;
    logic        da;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [27:0] exp_disp(input logic [1:0] s);
    case (s)
      2'd0:    exp_disp = {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
      2'd1:    exp_disp = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
      2'd2:    exp_disp = {7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000};
      default: exp_disp = {7'b1011110, 7'b1011100, 7'b1010100, 7'b1111001};
    endcase
  endfunction

  function automatic logic [6:0] digit(input logic [27:0] d, input int i);
    logic [6:0] r;
    case (i)
      0:       r = d[27:21];
      1:       r = d[20:14];
      2:       r = d[13:7];
      default: r = d[6:0];
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full state/output check against an expected state.
  task automatic check_state(input string name, input logic [1:0] st, input logic da);
    logic [27:0] d;
    int          sel;
    d = exp_disp(st);
    check({name, "_state"}, 32'(state_o), 32'(st));
    check({name, "_drop"}, 32'(drop_activated), 32'(da));
    check({name, "_segs"}, {4'h0, seven_seg1, seven_seg2, seven_seg3, seven_seg4}, {4'h0, d});
    case (an)
      4'b0001: sel = 0;
      4'b0010: sel = 1;
      4'b0100: sel = 2;
      4'b1000: sel = 3;
      default: sel = -1;
    endcase
    check({name, "_an_onehot"}, 32'(sel >= 0), 32'd1);
    if (sel >= 0) check({name, "_segmux"}, 32'(seg_mux), 32'(digit(d, sel)));
  endtask

  task automatic check_count(input string name);
`ifdef DROP_DISPLAY_SEQ_DROP_COUNT_EN
    check(name, 32'(drop_count), 32'(exp_cnt));
`else
    check(name, 32'(drop_activated), 32'd0);
`endif
  endtask

  // Wait (bounded) for DONE, recording a failure on timeout.
  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state_o == 2'd3) break;
    end
    check({name, "_reach_done"}, 32'(state_o), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int bad;

    vecs[0] = '{16'd20, 16'd30, 1'b0, 5,  2'd0, 1'b0};
    vecs[1] = '{16'd40, 16'd30, 1'b1, 5,  2'd2, 1'b0};
    vecs[2] = '{16'd40, 16'd30, 1'b0, 5,  2'd0, 1'b0};
    vecs[3] = '{16'd27, 16'd30, 1'b1, 5,  2'd0, 1'b0};
    vecs[4] = '{16'd30, 16'd30, 1'b1, 5,  2'd0, 1'b0};
    vecs[5] = '{16'd25, 16'd30, 1'b1, 5,  2'd0, 1'b0};
    vecs[6] = '{16'd24, 16'd30, 1'b1, 20, 2'd3, 1'b0};
    vecs[7] = '{16'd24, 16'd30, 1'b0, 5,  2'd0, 1'b0};
    vecs[8] = '{16'd31, 16'd30, 1'b1, 5,  2'd2, 1'b0};
    vecs[9] = '{16'd31, 16'd30, 1'b0, 5,  2'd0, 1'b0};

    rst_n   = 1'b0;
    t_act   = 16'd20;
    t_lim   = 16'd30;
    drop_en = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset", 2'd0, 1'b0);
    check("reset_an", 32'(an), 32'b0001);
    check_count("reset_count");
    rst_n = 1'b1;

    // Table: steady-state outcome per input pattern.
    for (int v = 0; v < 10; v++) begin
      t_act   = vecs[v].ta;
      t_lim   = vecs[v].tl;
      drop_en = vecs[v].en;
      repeat (vecs[v].cyc) @(negedge clk);
      check_state($sformatf("vec%0d", v), vecs[v].st, vecs[v].da);
    end
    exp_cnt = 1;
    check_count("count_after_table");

    // Exact synchroniser latency and pulse length.
    t_act   = 16'd20;
    drop_en = 1'b1;
    @(negedge clk);
    check("sync_lat1_state", 32'(state_o), 32'd0);
    @(negedge clk);
    check("sync_lat2_state", 32'(state_o), 32'd0);
    @(negedge clk);
    check_state("drop_start", 2'd1, 1'b1);
    pulses = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drop_activated) pulses++;
      if (state_o == 2'd3) break;
    end
    check("pulse_len", 32'(pulses), 32'd8);
    check_state("done", 2'd3, 1'b0);
    exp_cnt = 2;
    check_count("count_one_more");
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (drop_activated || state_o != 2'd3) bad++;
    end
    check("no_redrop_while_held", 32'(bad), 32'd0);
    drop_en = 1'b0;
    repeat (3) @(negedge clk);
    check_state("release_to_cold", 2'd0, 1'b0);

    // Abort at the third DROP cycle.
    drop_en = 1'b1;
    repeat (3) @(negedge clk);
    check_state("abort_drop1", 2'd1, 1'b1);
    repeat (2) @(negedge clk);
    check_state("abort_drop3", 2'd1, 1'b1);
    t_act = 16'd35;
    @(negedge clk);
    check_state("abort_hot", 2'd2, 1'b0);
    check_count("abort_not_counted");
    drop_en = 1'b0;
    t_act   = 16'd20;
    repeat (4) @(negedge clk);
    check_state("abort_release", 2'd0, 1'b0);

    // Three further completed drops: counter saturates at 3.
    for (int d = 0; d < 3; d++) begin
      drop_en = 1'b1;
      wait_done($sformatf("sat%0d", d));
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      check_count($sformatf("sat%0d_count", d));
      drop_en = 1'b0;
      repeat (4) @(negedge clk);
    end

    // Asynchronous reset in the middle of a drop.
    drop_en = 1'b1;
    repeat (5) @(negedge clk);
    check_state("pre_reset_drop", 2'd1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_drop", 32'(drop_activated), 32'd0);
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_an", 32'(an), 32'b0001);
    exp_cnt = 0;
    check_count("async_rst_count");
    drop_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_state("post_reset", 2'd0, 1'b0);

    // Scan: each digit held 4 clocks, wrapping 3 -> 0.
    for (int k = 1; k <= 32; k++) begin
      int ix;
      @(negedge clk);
      ix = (k / 4) % 4;
      check($sformatf("scan_an_k%0d", k), 32'(an), 32'(4'b0001 << ix));
      check($sformatf("scan_mux_k%0d", k), 32'(seg_mux), 32'(digit(exp_disp(2'd0), ix)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
